// File: rtl/lfsr_rand_gen.sv
// Pseudo-random value generator. Two XNOR LFSRs are stepped once per candidate. Their
// post-step states are bit-mixed into an OUT_W-bit candidate, and candidates equal to zero
// or to excl_val are retried up to MAX_TRIES times. The result is offered on a valid/ack
// handshake.
module lfsr_rand_gen #(
  parameter int unsigned       LFSR_W    = 16,
  parameter int unsigned       OUT_W     = 8,
  parameter int unsigned       DATA_W    = 16,
  parameter logic [LFSR_W-1:0] SEED_A    = 16'h6A47,
  parameter logic [LFSR_W-1:0] SEED_B    = 16'hF2DA,
  parameter int unsigned       MAX_TRIES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_a,
  input  logic [LFSR_W-1:0] seed_b,
  input  logic              req,
  input  logic [OUT_W-1:0]  excl_val,
  input  logic              ack,
  output logic              valid,
  output logic [DATA_W-1:0] out,
  output logic              retry_fail,
  output logic              busy
);

  localparam int unsigned TryW = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {StIdle, StStep, StDone} state_e;

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_a_q, lfsr_a_d;
  logic [LFSR_W-1:0] lfsr_b_q, lfsr_b_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic              retry_fail_q, retry_fail_d;
  logic [TryW-1:0]   tries_q, tries_d;

  logic [LFSR_W-1:0] a_next, b_next;
  logic [OUT_W-1:0]  cand;
  logic [TryW-1:0]   tries_inc;
  logic              reject, exhausted;

  // Shift left and feed back the XNOR of the two top bits.
  always_comb begin
    a_next = {lfsr_a_q[LFSR_W-2:0], ~(lfsr_a_q[LFSR_W-1] ^ lfsr_a_q[LFSR_W-2])};
    b_next = {lfsr_b_q[LFSR_W-2:0], ~(lfsr_b_q[LFSR_W-1] ^ lfsr_b_q[LFSR_W-2])};
  end

  // Odd candidate bits come from LFSR A, even bits from LFSR B, both taken post-step.
  for (genvar i = 0; i < OUT_W; i++) begin : g_mix
    if ((i % 2) == 1) begin : g_odd
      assign cand[i] = a_next[(2 * i) % LFSR_W];
    end else begin : g_even
      assign cand[i] = b_next[(2 * i + 1) % LFSR_W];
    end
  end

  // Candidate screening and retry bookkeeping.
  always_comb begin
    reject    = (cand == '0) || (cand == excl_val);
    tries_inc = tries_q + TryW'(1);
    exhausted = (tries_inc == TryW'(MAX_TRIES));
  end

  // Next-state logic; seed_load overrides every state.
  always_comb begin
    state_d      = state_q;
    lfsr_a_d     = lfsr_a_q;
    lfsr_b_d     = lfsr_b_q;
    out_d        = out_q;
    valid_d      = valid_q;
    retry_fail_d = retry_fail_q;
    tries_d      = tries_q;

    case (state_q)
      StIdle: begin
        if (req) begin
          tries_d      = '0;
          retry_fail_d = 1'b0;
          state_d      = StStep;
        end
      end
      StStep: begin
        lfsr_a_d = a_next;
        lfsr_b_d = b_next;
        tries_d  = tries_inc;
        if (!reject || exhausted) begin
          out_d        = DATA_W'(cand);
          valid_d      = 1'b1;
          // Set only when the candidate went out because the retry budget ran out.
          retry_fail_d = reject;
          state_d      = StDone;
        end
      end
      StDone: begin
        if (ack) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (seed_load) begin
      // An all-ones seed would lock an XNOR LFSR, so fall back to the default seed.
      lfsr_a_d = (seed_a == '1) ? SEED_A : seed_a;
      lfsr_b_d = (seed_b == '1) ? SEED_B : seed_b;
      state_d  = StIdle;
      valid_d  = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      lfsr_a_q     <= SEED_A;
      lfsr_b_q     <= SEED_B;
      out_q        <= '0;
      valid_q      <= 1'b0;
      retry_fail_q <= 1'b0;
      tries_q      <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_a_q     <= lfsr_a_d;
      lfsr_b_q     <= lfsr_b_d;
      out_q        <= out_d;
      valid_q      <= valid_d;
      retry_fail_q <= retry_fail_d;
      tries_q      <= tries_d;
    end
  end

  // Outputs come straight from registered state.
  always_comb begin
    valid      = valid_q;
    out        = out_q;
    retry_fail = retry_fail_q;
    busy       = (state_q == StStep);
  end

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen: a default instance plus a MAX_TRIES=1 instance that
// shares the seed and exclusion inputs but has its own req/ack.
module tb_lfsr_rand_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [15:0] seed_a, seed_b;
  logic        req, ack, req1, ack1;
  logic [7:0]  excl_val;
  logic        valid, retry_fail, busy;
  logic [15:0] out;
  logic        valid1, retry_fail1, busy1;
  logic [15:0] out1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_rand_gen dut (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (seed_load),
    .seed_a     (seed_a),
    .seed_b     (seed_b),
    .req        (req),
    .excl_val   (excl_val),
    .ack        (ack),
    .valid      (valid),
    .out        (out),
    .retry_fail (retry_fail),
    .busy       (busy)
  );

  lfsr_rand_gen #(.MAX_TRIES(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (seed_load),
    .seed_a     (seed_a),
    .seed_b     (seed_b),
    .req        (req1),
    .excl_val   (excl_val),
    .ack        (ack1),
    .valid      (valid1),
    .out        (out1),
    .retry_fail (retry_fail1),
    .busy       (busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; seed_load = 1'b0; seed_a = '0; seed_b = '0;
    req = 1'b0; ack = 1'b0; req1 = 1'b0; ack1 = 1'b0; excl_val = '0;
    #12;
    check("rst_out", 32'(out), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_retry", 32'(retry_fail), 32'h0);
    check("rst_lfsr_a", 32'(dut.lfsr_a_q), 32'h6A47);
    check("rst_lfsr_b", 32'(dut.lfsr_b_q), 32'hF2DA);
    tick();
    rst = 1'b1;
    tick();

    // Seeds 0/0, excl 0x55: 0x00 rejected, then 0x01 accepted on the second try.
    seed_load = 1'b1; seed_a = 16'h0000; seed_b = 16'h0000;
    tick();
    seed_load = 1'b0;
    check("load_a0", 32'(dut.lfsr_a_q), 32'h0);
    req = 1'b1; excl_val = 8'h55;
    tick();
    req = 1'b0;
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_valid0", 32'(valid), 32'h0);
    tick();
    check("t1_valid_try1", 32'(valid), 32'h0);
    check("t1_lfsr_a_try1", 32'(dut.lfsr_a_q), 32'h0001);
    tick();
    check("t1_valid", 32'(valid), 32'h1);
    check("t1_out", 32'(out), 32'h0001);
    check("t1_retry", 32'(retry_fail), 32'h0);
    check("t1_busy_done", 32'(busy), 32'h0);

    // Hold without ack: output and LFSRs frozen.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_out", 32'(out), 32'h0001);
      check("hold_lfsr_a", 32'(dut.lfsr_a_q), 32'h0003);
      check("hold_valid", 32'(valid), 32'h1);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_valid", 32'(valid), 32'h0);
    check("ack_out", 32'(out), 32'h0001);

    // Seeds 0/0, excl 0x01: 0x00 and 0x01 rejected, 0x03 on the third try.
    seed_load = 1'b1; seed_a = 16'h0000; seed_b = 16'h0000; excl_val = 8'h01;
    tick();
    seed_load = 1'b0;
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    check("t2_valid_try2", 32'(valid), 32'h0);
    check("t2_busy_try2", 32'(busy), 32'h1);
    tick();
    check("t2_valid", 32'(valid), 32'h1);
    check("t2_out", 32'(out), 32'h0003);
    check("t2_retry", 32'(retry_fail), 32'h0);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // MAX_TRIES=1 instance, still at seeds 0/0: exhaustion on a rejected 0x00.
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    check("m1_busy", 32'(busy1), 32'h1);
    tick();
    check("m1_valid", 32'(valid1), 32'h1);
    check("m1_out", 32'(out1), 32'h0000);
    check("m1_retry", 32'(retry_fail1), 32'h1);
    check("m1_lfsr_a", 32'(dut1.lfsr_a_q), 32'h0001);

    // Abort mid-STEP with an all-ones seed_a.
    seed_load = 1'b1; seed_a = 16'h0000; seed_b = 16'h0000; excl_val = 8'h01;
    tick();
    seed_load = 1'b0;
    check("abort_m1_valid", 32'(valid1), 32'h0);
    check("abort_m1_out", 32'(out1), 32'h0000);
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    check("abort_pre_busy", 32'(busy), 32'h1);
    seed_load = 1'b1; seed_a = 16'hFFFF; seed_b = 16'h1234;
    tick();
    seed_load = 1'b0;
    check("abort_lfsr_a", 32'(dut.lfsr_a_q), 32'h6A47);
    check("abort_lfsr_b", 32'(dut.lfsr_b_q), 32'h1234);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_valid", 32'(valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_result", 32'(valid), 32'h0);
      check("abort_out_kept", 32'(out), 32'h0003);
    end

    // All-ones seed_b falls back to the default.
    seed_load = 1'b1; seed_a = 16'h0000; seed_b = 16'hFFFF;
    tick();
    seed_load = 1'b0;
    check("guard_lfsr_a", 32'(dut.lfsr_a_q), 32'h0000);
    check("guard_lfsr_b", 32'(dut.lfsr_b_q), 32'hF2DA);

    // Reset mid-STEP returns everything to reset values.
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_valid", 32'(valid), 32'h0);
    check("rst_mid_out", 32'(out), 32'h0);
    check("rst_mid_lfsr_b", 32'(dut.lfsr_b_q), 32'hF2DA);
    tick();
    rst = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
